// File: rtl/fpu_issue_ctrl.sv
// Issue controller for attached FPU units: takes one op from the core, orders the selected
// unit, holds the shared operands until done, and returns the result on a write-back port.
module fpu_issue_ctrl #(
  parameter int N_UNITS = 4,
  parameter int SEL_W   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [SEL_W-1:0]     req_unit,
  input  logic [31:0]          req_rs1,
  input  logic [31:0]          req_rs2,
  input  logic [4:0]           req_tag,
  output logic [N_UNITS-1:0]   order,
  input  logic [N_UNITS-1:0]   accepted,
  input  logic [N_UNITS-1:0]   done,
  input  logic [32*N_UNITS-1:0] unit_rd,
  output logic [31:0]          fpu_rs1,
  output logic [31:0]          fpu_rs2,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [31:0]          wb_data,
  output logic [4:0]           wb_tag,
  output logic                 wb_err,
  output logic [1:0]           dbg_state
);

  // Handshakes: a transfer happens on a clk edge where both valid and ready are high;
  // valid and its payload stay stable until that edge, ready may depend on state only.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ORDER = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  localparam logic [SEL_W:0] N_UNITS_W = (SEL_W+1)'(N_UNITS);
  localparam logic [7:0]     TIMEOUT_W = 8'(TIMEOUT);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q;
  logic [31:0]        rs1_q, rs2_q, wb_data_q;
  logic [4:0]         tag_q;
  logic               wb_err_q;
  logic [7:0]         cnt_q;

  logic [N_UNITS-1:0] sel_hot;
  logic               acc_sel, done_sel, unit_bad, timed_out;
  logic [31:0]        rd_sel;

  // Selected-unit view; built from a one-hot so sel_q never indexes past N_UNITS.
  always_comb begin
    sel_hot = '0;
    rd_sel  = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      sel_hot[i] = (sel_q == SEL_W'(i));
      if (sel_hot[i]) rd_sel = unit_rd[32*i +: 32];
    end
  end

  assign acc_sel   = |(accepted & sel_hot);
  assign done_sel  = |(done & sel_hot);
  assign unit_bad  = ({1'b0, req_unit} >= N_UNITS_W);
  assign timed_out = (cnt_q == TIMEOUT_W);

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = unit_bad ? S_WB : S_ORDER;
      S_ORDER: if (acc_sel) state_d = done_sel ? S_WB : S_WAIT;
      S_WAIT:  if (done_sel || timed_out) state_d = S_WB;
      S_WB:    if (wb_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == S_IDLE);
    wb_valid  = (state_q == S_WB);
    dbg_state = state_q;
    order     = '0;
    for (int i = 0; i < N_UNITS; i++) order[i] = (state_q == S_ORDER) && sel_hot[i];
  end

  // Operands stay latched until the next accept, so units may sample them at any point.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sel_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      tag_q     <= '0;
      wb_data_q <= '0;
      wb_err_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            sel_q     <= req_unit;
            rs1_q     <= req_rs1;
            rs2_q     <= req_rs2;
            tag_q     <= req_tag;
            wb_data_q <= '0;
            wb_err_q  <= unit_bad;
          end
        end
        S_ORDER: begin
          cnt_q <= '0;
          if (acc_sel && done_sel) begin
            wb_data_q <= rd_sel;
            wb_err_q  <= 1'b0;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          if (done_sel) begin
            wb_data_q <= rd_sel;
            wb_err_q  <= 1'b0;
          end else if (timed_out) begin
            wb_data_q <= '0;
            wb_err_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign fpu_rs1 = rs1_q;
  assign fpu_rs2 = rs2_q;
  assign wb_data = wb_data_q;
  assign wb_tag  = tag_q;
  assign wb_err  = wb_err_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl with stub FPU units and an expected write-back queue.
module tb_fpu_issue_ctrl;

  logic         clk, rstn;
  logic         req_valid, req_ready;
  logic [2:0]   req_unit;
  logic [31:0]  req_rs1, req_rs2;
  logic [4:0]   req_tag;
  logic [3:0]   order, accepted, done;
  logic [127:0] unit_rd;
  logic [31:0]  fpu_rs1, fpu_rs2;
  logic         wb_valid, wb_ready;
  logic [31:0]  wb_data;
  logic [4:0]   wb_tag;
  logic         wb_err;
  logic [1:0]   dbg_state;

  fpu_issue_ctrl #(.N_UNITS(4), .SEL_W(3), .TIMEOUT(255)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_unit(req_unit),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
    .order(order), .accepted(accepted), .done(done), .unit_rd(unit_rd),
    .fpu_rs1(fpu_rs1), .fpu_rs2(fpu_rs2),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_tag(wb_tag), .wb_err(wb_err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  // stub units: accept gated by acc_en, done after dlat cycles (0 = never)
  logic [3:0]  acc_en, imm_en, spur, done_r, busy;
  logic [31:0] rd_val [4];
  int          dlat [4];
  int          dcnt [4];

  assign accepted = order & acc_en;
  assign done     = done_r | (accepted & imm_en) | spur;

  always_comb begin
    unit_rd = '0;
    for (int i = 0; i < 4; i++)
      unit_rd[32*i +: 32] = done[i] ? rd_val[i] : {16'hdead, 16'(i)};
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      done_r[i] <= 1'b0;
      if (!rstn) begin
        busy[i] <= 1'b0;
      end else if (busy[i]) begin
        if (dcnt[i] == 1) begin
          done_r[i] <= 1'b1;
          busy[i]   <= 1'b0;
        end else if (dcnt[i] > 1) begin
          dcnt[i] <= dcnt[i] - 1;
        end
      end else if (order[i] && accepted[i]) begin
        busy[i] <= 1'b1;
        dcnt[i] <= dlat[i];
      end
    end
  end

  // scoreboard: {err, tag, data}
  logic [37:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic issue(input logic [2:0] unit, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] exp_data, input logic exp_err);
    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_unit  = unit;
    req_rs1   = a;
    req_rs2   = b;
    req_tag   = tag;
    exp_q.push_back({exp_err, tag, exp_data});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_wb(input int budget);
    int n;
    n = 0;
    while (wb_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wb_valid_wait", wb_valid, 1'b1);
  endtask

  task automatic finish_wb();
    logic [37:0] e;
    check("sb_nonempty", exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("wb_data", wb_data, e[31:0]);
      check("wb_tag", wb_tag, e[36:32]);
      check("wb_err", wb_err, e[37]);
    end
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    check("wb_drop", wb_valid, 1'b0);
    check("req_ready_back", req_ready, 1'b1);
  endtask

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_unit = '0; req_rs1 = '0; req_rs2 = '0; req_tag = '0;
    wb_ready = 1'b0; acc_en = 4'hf; imm_en = 4'h0; spur = 4'h0;
    for (int i = 0; i < 4; i++) begin rd_val[i] = 32'h0; dlat[i] = 2; end
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_order", order, 4'h0);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_wb_tag", wb_tag, 5'h0);
    check("rst_wb_err", wb_err, 1'b0);
    check("rst_rs1", fpu_rs1, 32'h0);
    check("rst_rs2", fpu_rs2, 32'h0);
    check("rst_state", dbg_state, 2'd0);
    rstn = 1'b1;
    @(negedge clk);

    // fdiv on unit 2 with exact latency; stray done on unit 0 while waiting
    rd_val[2] = 32'h40400000; rd_val[0] = 32'h11111111;
    issue(3'd2, 32'h40C00000, 32'h40000000, 5'd7, 32'h40400000, 1'b0);
    check("t1_order_t1", order, 4'b0100);
    check("t1_rs1", fpu_rs1, 32'h40C00000);
    check("t1_rs2", fpu_rs2, 32'h40000000);
    @(negedge clk);
    check("t1_order_t2", order, 4'b0000);
    check("t1_wbv_t2", wb_valid, 1'b0);
    spur = 4'b0001;
    @(negedge clk);
    spur = 4'b0000;
    check("t1_wbv_t3", wb_valid, 1'b0);
    @(negedge clk);
    check("t1_wbv_t4", wb_valid, 1'b0);
    @(negedge clk);
    check("t1_wbv_t5", wb_valid, 1'b1);
    finish_wb();

    // unit 3 withholds accept for 3 cycles
    acc_en = 4'b0111; rd_val[3] = 32'h3F800000;
    issue(3'd3, 32'h12345678, 32'h9ABCDEF0, 5'd3, 32'h3F800000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("t2_order_hold", order, 4'b1000);
      check("t2_rs1_hold", fpu_rs1, 32'h12345678);
      check("t2_rs2_hold", fpu_rs2, 32'h9ABCDEF0);
      @(negedge clk);
    end
    acc_en = 4'hf;
    check("t2_order_acc", order, 4'b1000);
    @(negedge clk);
    check("t2_order_drop", order, 4'b0000);
    check("t2_rs1_wait", fpu_rs1, 32'h12345678);
    wait_wb(10);
    check("t2_rs2_wb", fpu_rs2, 32'h9ABCDEF0);
    finish_wb();

    // invalid unit index
    issue(3'd5, 32'hAAAA5555, 32'h5555AAAA, 5'd21, 32'h0, 1'b1);
    check("t4_no_order", order, 4'h0);
    check("t4_wbv_next", wb_valid, 1'b1);
    finish_wb();

    // write-back backpressure with a competing request
    rd_val[1] = 32'hC0000000;
    issue(3'd1, 32'h3F000000, 32'h3E800000, 5'd9, 32'hC0000000, 1'b0);
    wait_wb(10);
    req_valid = 1'b1; req_unit = 3'd2; req_rs1 = 32'hFFFF0000; req_rs2 = 32'h0000FFFF; req_tag = 5'd30;
    for (int k = 0; k < 10; k++) begin
      check("t5_wbv_hold", wb_valid, 1'b1);
      check("t5_data_hold", wb_data, 32'hC0000000);
      check("t5_tag_hold", wb_tag, 5'd9);
      check("t5_err_hold", wb_err, 1'b0);
      check("t5_req_ready", req_ready, 1'b0);
      check("t5_rs1_hold", fpu_rs1, 32'h3F000000);
      @(negedge clk);
    end
    req_valid = 1'b0;
    finish_wb();
    @(negedge clk);
    check("t5_not_taken", order, 4'h0);
    check("t5_idle", dbg_state, 2'd0);

    // accept and done in the order cycle
    imm_en = 4'b0001; dlat[0] = 0; rd_val[0] = 32'h40490FDB;
    issue(3'd0, 32'h1, 32'h2, 5'd12, 32'h40490FDB, 1'b0);
    check("imm_order", order, 4'b0001);
    @(negedge clk);
    imm_en = 4'b0000;
    check("imm_wbv", wb_valid, 1'b1);
    check("imm_order_drop", order, 4'h0);
    finish_wb();

    // watchdog timeout: unit 0 never completes
    issue(3'd0, 32'h3, 32'h4, 5'd30, 32'h0, 1'b1);
    check("t3_order", order, 4'b0001);
    repeat (256) @(negedge clk);
    check("t3_wbv_early", wb_valid, 1'b0);
    @(negedge clk);
    check("t3_wbv", wb_valid, 1'b1);
    finish_wb();

    // reset mid-WAIT, then a normal op
    issue(3'd0, 32'h5, 32'h6, 5'd4, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    check("t6_in_wait", dbg_state, 2'd2);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    exp_q.delete();
    check("t6_req_ready", req_ready, 1'b1);
    check("t6_order", order, 4'h0);
    check("t6_wbv", wb_valid, 1'b0);
    check("t6_rs1", fpu_rs1, 32'h0);
    check("t6_err", wb_err, 1'b0);
    dlat[0] = 2; rd_val[0] = 32'h40A00000;
    @(negedge clk);
    issue(3'd0, 32'h40000000, 32'h40400000, 5'd5, 32'h40A00000, 1'b0);
    wait_wb(10);
    finish_wb();

    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
